// File: rtl/vram_cycle_sequencer.sv
// vram_cycle_sequencer: runs one VRAM bus cycle (read or write) at a time
// on the two SNES VRAM chips (A = low byte, B = high byte). The cycle has
// an address setup phase, a strobe phase and a hold phase. Read data goes
// back over a valid/ready response channel.
//
// Optional feature: define VRAM_SEQ_AUTOINC_EN to add cmd_use_next_i and
// next_addr_o. This lets a command reuse the previous address + 1.
//
// All pin-facing outputs come straight from flops. The strobe and
// direction flops load from the next-state decode, so each pin changes on
// the same edge as the state it belongs to.
module vram_cycle_sequencer #(
  parameter int SETUP_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int DUR_W        = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [1:0]       cmd_bytes_i,
  input  logic [14:0]      cmd_addr_i,
  input  logic [15:0]      cmd_wdata_i,
`ifdef VRAM_SEQ_AUTOINC_EN
  input  logic             cmd_use_next_i,
  output logic [14:0]      next_addr_o,
`endif
  input  logic [DUR_W-1:0] write_duration_i,
  input  logic [DUR_W-1:0] read_delay_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [15:0]      rsp_data_o,
  output logic             vrd_n_o,
  output logic             vawr_n_o,
  output logic             vbwr_n_o,
  output logic             va14_o,
  output logic [13:0]      vaa_o,
  output logic [13:0]      vab_o,
  output logic             vd_dir_o,
  output logic [7:0]       vda_o,
  output logic [7:0]       vdb_o,
  input  logic [7:0]       vda_i,
  input  logic [7:0]       vdb_i,
  output logic             busy_o,
  output logic             error_zero_bytes_o
);

  // The phase counter has to hold the longest read strobe (read_delay + 1,
  // up to 2^DUR_W cycles, so DUR_W+1 bits). It also has to hold the setup
  // and hold lengths.
  localparam int SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int PH_W    = (SETUP_W > HOLD_W) ? SETUP_W : HOLD_W;
  localparam int CNT_W   = ((DUR_W + 1) > PH_W) ? (DUR_W + 1) : PH_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               zero_cmd;
  logic               capture;

  // Command fields latched at acceptance
  logic               write_q;
  logic [1:0]         bytes_q;
  logic [14:0]        addr_q;
  logic [15:0]        wdata_q;
  logic [DUR_W-1:0]   wdur_q;
  logic [DUR_W-1:0]   rdel_q;

  // Values the latched fields will hold after this edge
  logic               write_d;
  logic [1:0]         bytes_d;
  logic [14:0]        sel_addr;

  logic               vrd_n_q, vawr_n_q, vbwr_n_q, vd_dir_q;
  logic [15:0]        rsp_data_q;
  logic               error_q;

`ifdef VRAM_SEQ_AUTOINC_EN
  logic [14:0]        next_addr_q;
  assign sel_addr    = cmd_use_next_i ? next_addr_q : cmd_addr_i;
  assign next_addr_o = next_addr_q;
`else
  assign sel_addr    = cmd_addr_i;
`endif

  assign write_d = accept ? cmd_write_i : write_q;
  assign bytes_d = accept ? cmd_bytes_i : bytes_q;

  // Next-state, phase counter and handshake decode
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    zero_cmd = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_bytes_i == 2'b00) begin
            // An empty command is taken and flagged. It never touches the bus.
            zero_cmd = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = ST_SETUP;
            cnt_d   = CNT_W'(SETUP_CYCLES - 1);
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          if (write_q)
            cnt_d = (wdur_q == '0) ? '0 : CNT_W'(wdur_q) - CNT_W'(1);
          else
            cnt_d = CNT_W'(rdel_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          // The last low cycle of a read strobe is when data is sampled
          capture = !write_q;
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0)
          state_d = write_q ? ST_IDLE : ST_RESP;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        if (rsp_ready_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and phase counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the command. Address and data pins change only here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      bytes_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wdur_q  <= '0;
      rdel_q  <= '0;
    end else if (accept) begin
      write_q <= cmd_write_i;
      bytes_q <= cmd_bytes_i;
      addr_q  <= sel_addr;
      wdata_q <= cmd_wdata_i;
      wdur_q  <= write_duration_i;
      rdel_q  <= read_delay_i;
    end
  end

  // Strobe and data-direction pins, loaded from the state being entered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vrd_n_q  <= 1'b1;
      vawr_n_q <= 1'b1;
      vbwr_n_q <= 1'b1;
      vd_dir_q <= 1'b0;
    end else begin
      vrd_n_q  <= !((state_d == ST_STROBE) && !write_d);
      vawr_n_q <= !((state_d == ST_STROBE) && write_d && bytes_d[0]);
      vbwr_n_q <= !((state_d == ST_STROBE) && write_d && bytes_d[1]);
      vd_dir_q <= write_d && ((state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                              (state_d == ST_HOLD));
    end
  end

  // Read-data capture. Bytes that are not selected read back as 0x00.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      rsp_data_q <= '0;
    else if (capture)
      rsp_data_q <= {bytes_q[1] ? vdb_i : 8'h00, bytes_q[0] ? vda_i : 8'h00};
  end

  // Sticky flag for commands that enable no byte
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      error_q <= 1'b0;
    else if (zero_cmd)
      error_q <= 1'b1;
  end

`ifdef VRAM_SEQ_AUTOINC_EN
  // Auto-increment address, updated as a cycle leaves HOLD (15-bit wrap)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      next_addr_q <= '0;
    else if ((state_q == ST_HOLD) && (state_d != ST_HOLD))
      next_addr_q <= addr_q + 15'd1;
  end
`endif

  assign cmd_ready_o        = (state_q == ST_IDLE);
  assign busy_o             = (state_q != ST_IDLE);
  assign rsp_valid_o        = (state_q == ST_RESP);
  assign rsp_data_o         = rsp_data_q;
  assign error_zero_bytes_o = error_q;
  assign vrd_n_o            = vrd_n_q;
  assign vawr_n_o           = vawr_n_q;
  assign vbwr_n_o           = vbwr_n_q;
  assign vd_dir_o           = vd_dir_q;
  assign va14_o             = addr_q[14];
  assign vaa_o              = addr_q[13:0];
  assign vab_o              = addr_q[13:0];
  assign vda_o              = wdata_q[7:0];
  assign vdb_o              = wdata_q[15:8];

endmodule

// File: tb/tb_vram_cycle_sequencer.sv
// Directed testbench for vram_cycle_sequencer (default parameters:
// SETUP_CYCLES=2, HOLD_CYCLES=1, DUR_W=6). Cycle k is the period after the
// k-th rising edge that follows the acceptance edge. Outputs are sampled 1
// time unit after the rising edge.
module tb_vram_cycle_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_bytes = 2'b00;
  logic [14:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [5:0]  write_duration = '0;
  logic [5:0]  read_delay = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        vrd_n, vawr_n, vbwr_n, va14, vd_dir;
  logic [13:0] vaa, vab;
  logic [7:0]  vda, vdb;
  logic [7:0]  vda_in = 8'h5A;
  logic [7:0]  vdb_in = 8'hA5;
  logic        busy, error_zero;
`ifdef VRAM_SEQ_AUTOINC_EN
  logic        use_next = 1'b0;
  logic [14:0] next_addr;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  vram_cycle_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_write_i        (cmd_write),
    .cmd_bytes_i        (cmd_bytes),
    .cmd_addr_i         (cmd_addr),
    .cmd_wdata_i        (cmd_wdata),
`ifdef VRAM_SEQ_AUTOINC_EN
    .cmd_use_next_i     (use_next),
    .next_addr_o        (next_addr),
`endif
    .write_duration_i   (write_duration),
    .read_delay_i       (read_delay),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_data_o         (rsp_data),
    .vrd_n_o            (vrd_n),
    .vawr_n_o           (vawr_n),
    .vbwr_n_o           (vbwr_n),
    .va14_o             (va14),
    .vaa_o              (vaa),
    .vab_o              (vab),
    .vd_dir_o           (vd_dir),
    .vda_o              (vda),
    .vdb_o              (vdb),
    .vda_i              (vda_in),
    .vdb_i              (vdb_in),
    .busy_o             (busy),
    .error_zero_bytes_o (error_zero)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one command for one edge. On return the bench is in cycle 1.
  task automatic issue(input logic wr, input logic [1:0] by, input logic [14:0] a,
                       input logic [15:0] d, input logic [5:0] wd, input logic [5:0] rd);
    cmd_write      = wr;
    cmd_bytes      = by;
    cmd_addr       = a;
    cmd_wdata      = d;
    write_duration = wd;
    read_delay     = rd;
    cmd_valid      = 1'b1;
    tick();
    cmd_valid      = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    #12;
    got = {vrd_n, vawr_n, vbwr_n, vd_dir, rsp_valid, busy};
    total++;
    if (got !== 6'b111000) begin
      bad++;
      $display("FAIL reset_pins got=%b want=111000", got);
    end
    total++;
    if ({va14, vaa, vab, vda, vdb, rsp_data, error_zero} !== 62'd0) begin
      bad++;
      $display("FAIL reset_zero got=%h want=0", {va14, vaa, vab, vda, vdb, rsp_data, error_zero});
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    total++;
    if ({cmd_ready, rsp_valid, error_zero, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release got=%b want=1000", {cmd_ready, rsp_valid, error_zero, busy});
    end
  endtask

  task automatic test_write_both();
    logic [4:0] got, want;
    issue(1'b1, 2'b11, 15'h4123, 16'hBEEF, 6'd3, 6'd0);
    total++;
    if ({va14, vaa, vab, vdb, vda} !== {1'b1, 14'h0123, 14'h0123, 8'hBE, 8'hEF}) begin
      bad++;
      $display("FAIL wr_addr_data got=%b,%h,%h,%h,%h want=1,0123,0123,be,ef",
               va14, vaa, vab, vdb, vda);
    end
    // {vd_dir, vawr_n, vbwr_n, vrd_n, cmd_ready}
    for (int k = 1; k <= 8; k++) begin
      if (k <= 2 || k == 6) want = 5'b11110;
      else if (k <= 5)      want = 5'b10010;
      else                  want = 5'b01111;
      got = {vd_dir, vawr_n, vbwr_n, vrd_n, cmd_ready};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wr_cycle%0d got=%b want=%b", k, got, want);
      end
      tick();
    end
  endtask

  task automatic test_read_low();
    logic [3:0] got, want;
    issue(1'b0, 2'b01, 15'h0010, 16'h0000, 6'd0, 6'd0);
    // {vd_dir, vrd_n, rsp_valid, cmd_ready}
    for (int k = 1; k <= 5; k++) begin
      if (k == 3)      want = 4'b0000;
      else if (k == 5) want = 4'b0110;
      else             want = 4'b0100;
      got = {vd_dir, vrd_n, rsp_valid, cmd_ready};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL rd_cycle%0d got=%b want=%b", k, got, want);
      end
      if (k < 5) tick();
    end
    // Hold the response while another command is offered
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_bytes = 2'b11;
    cmd_addr  = 15'h3333;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_data, cmd_ready, vaa, vrd_n, vd_dir} !==
          {1'b1, 16'h005A, 1'b0, 14'h0010, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL rd_resp_hold%0d got=%b,%h,%b,%h,%b,%b want=1,005a,0,0010,1,0",
                 i, rsp_valid, rsp_data, cmd_ready, vaa, vrd_n, vd_dir);
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, cmd_ready, vaa} !== {1'b0, 1'b1, 14'h0010}) begin
      bad++;
      $display("FAIL rd_resp_taken got=%b,%b,%h want=0,1,0010", rsp_valid, cmd_ready, vaa);
    end
  endtask

  task automatic test_long_read();
    int lows = 0;
    int lat = 0;
    logic done = 1'b0;
    issue(1'b0, 2'b10, 15'h0200, 16'h0000, 6'd0, 6'd63);
    for (int k = 1; k <= 200 && !done; k++) begin
      if (vrd_n === 1'b0) lows++;
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
        lat  = k;
      end else begin
        tick();
      end
    end
    total++;
    if (!done || lows != 64 || lat != 68) begin
      bad++;
      $display("FAIL rd63_timing got done=%0d lows=%0d lat=%0d want 1 64 68", done, lows, lat);
    end
    total++;
    if (rsp_data !== 16'hA500) begin
      bad++;
      $display("FAIL rd63_data got=%h want=a500", rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_write_high_zero_dur();
    logic [3:0] got, want;
    issue(1'b1, 2'b10, 15'h0055, 16'h1234, 6'd0, 6'd0);
    // {vawr_n, vbwr_n, vrd_n, cmd_ready}
    for (int k = 1; k <= 5; k++) begin
      if (k == 3)      want = 4'b1010;
      else if (k == 5) want = 4'b1111;
      else             want = 4'b1110;
      got = {vawr_n, vbwr_n, vrd_n, cmd_ready};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL wrb_cycle%0d got=%b want=%b", k, got, want);
      end
      tick();
    end
  endtask

  task automatic test_zero_bytes();
    issue(1'b1, 2'b00, 15'h0777, 16'hFFFF, 6'd2, 6'd0);
    for (int k = 1; k <= 4; k++) begin
      total++;
      if ({error_zero, cmd_ready, busy, vawr_n, vbwr_n, vrd_n, vd_dir} !== 7'b1101110) begin
        bad++;
        $display("FAIL zero_bytes%0d got=%b want=1101110", k,
                 {error_zero, cmd_ready, busy, vawr_n, vbwr_n, vrd_n, vd_dir});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_strobe();
    issue(1'b1, 2'b11, 15'h2AAA, 16'hCAFE, 6'd3, 6'd0);
    tick();
    tick();
    total++;
    if ({vawr_n, vbwr_n, vd_dir} !== 3'b001) begin
      bad++;
      $display("FAIL mid_strobe_pre got=%b want=001", {vawr_n, vbwr_n, vd_dir});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({vawr_n, vbwr_n, vrd_n, vd_dir, busy, error_zero, rsp_valid} !== 7'b1110000) begin
      bad++;
      $display("FAIL mid_strobe_reset got=%b want=1110000",
               {vawr_n, vbwr_n, vrd_n, vd_dir, busy, error_zero, rsp_valid});
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({cmd_ready, busy, vawr_n, vbwr_n, vd_dir} !== 5'b10110) begin
      bad++;
      $display("FAIL mid_strobe_after got=%b want=10110", {cmd_ready, busy, vawr_n, vbwr_n, vd_dir});
    end
  endtask

`ifdef VRAM_SEQ_AUTOINC_EN
  task automatic wait_idle(input string name);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout got ready=%b want=1", name, cmd_ready);
    end
  endtask

  task automatic test_autoinc();
    use_next = 1'b0;
    issue(1'b1, 2'b11, 15'h7FFF, 16'h0101, 6'd1, 6'd0);
    wait_idle("autoinc_first");
    total++;
    if (next_addr !== 15'h0000) begin
      bad++;
      $display("FAIL autoinc_wrap got=%h want=0000", next_addr);
    end
    use_next = 1'b1;
    issue(1'b1, 2'b11, 15'h1234, 16'h0202, 6'd1, 6'd0);
    use_next = 1'b0;
    total++;
    if ({va14, vaa, vab} !== 29'd0) begin
      bad++;
      $display("FAIL autoinc_addr got=%b,%h,%h want=0,0000,0000", va14, vaa, vab);
    end
    wait_idle("autoinc_second");
    total++;
    if (next_addr !== 15'h0001) begin
      bad++;
      $display("FAIL autoinc_next got=%h want=0001", next_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_both();
    test_read_low();
    test_long_read();
    test_write_high_zero_dur();
    test_zero_bytes();
    test_reset_mid_strobe();
`ifdef VRAM_SEQ_AUTOINC_EN
    test_autoinc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
